// File: rtl/seg_scan_ctrl_if.sv
// Scan controller bus: scan enable, digit values and per-digit flags
// toward the controller, and decoder nibble / anodes / decimal point /
// frame pulse back from it.
//   master : drives en, x, dig_en, dp_in; observes digit, an, dp, frame_done
//   slave  : the scan controller itself
interface seg_scan_ctrl_if #(
    parameter int NDIG = 6
);
    logic                en;
    logic [4*NDIG-1:0]   x;
    logic [NDIG-1:0]     dig_en;
    logic [NDIG-1:0]     dp_in;
    logic [3:0]          digit;
    logic [NDIG-1:0]     an;
    logic                dp;
    logic                frame_done;

    modport master (
        output en, x, dig_en, dp_in,
        input  digit, an, dp, frame_done
    );

    modport slave (
        input  en, x, dig_en, dp_in,
        output digit, an, dp, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller. One slot of DIV_MAX+1 clocks
// per digit; the first BLANK_CYC clocks of a slot keep all anodes off to
// avoid ghosting. The display value is captured once per frame (slot 0,
// cnt 0) so a digit update mid-frame never tears.
// Ports:
//   clk  : system clock
//   clr  : synchronous active-high reset
//   bus  : seg_scan_ctrl_if.slave
//          en         scan enable (0 = dark, scan frozen)
//          x          digit values, digit i = x[4i+3:4i]
//          dig_en     per-digit show enable
//          dp_in      per-digit decimal point
//          digit      nibble to the shared decoder
//          an         active-low anodes
//          dp         active-low decimal point
//          frame_done one-clock pulse after the last slot of a frame
module seg_scan_ctrl #(
    parameter int NDIG      = 6,
    parameter int DIV_W     = 16,
    parameter int DIV_MAX   = 49999,
    parameter int BLANK_CYC = 2
) (
    input  logic              clk,
    input  logic              clr,
    seg_scan_ctrl_if.slave    bus
);
    localparam int               IW    = $clog2(NDIG);
    localparam logic [DIV_W-1:0] CMAX  = DIV_W'(DIV_MAX);
    localparam logic [DIV_W-1:0] CBLK  = DIV_W'(BLANK_CYC);
    localparam logic [IW-1:0]    ILAST = IW'(NDIG-1);

    typedef enum logic { BLANK, DRIVE } phase_t;
    // Phase matching cnt==0, the reset count.
    localparam phase_t ST_RST = (BLANK_CYC > 0) ? BLANK : DRIVE;

    logic [DIV_W-1:0]     cnt, cnt_nx;
    logic [IW-1:0]        idx, idx_nx;
    logic [NDIG-1:0][3:0] snap_x, cur_x;
    logic [NDIG-1:0]      snap_en, snap_dp, cur_en, cur_dp;
    logic                 tick, load;
    phase_t               st, st_nx;

    logic [NDIG-1:0]      an_q, an_nx;
    logic                 dp_q, dp_nx;
    logic [3:0]           digit_q, digit_nx;
    logic                 fd_q, fd_nx;

    // Counter / snapshot control
    always_comb begin
        tick = (cnt == CMAX);
        load = bus.en && (cnt == '0) && (idx == '0);
        // Bypass: on the load cycle the outputs already reflect the new inputs.
        cur_x  = load ? bus.x      : snap_x;
        cur_en = load ? bus.dig_en : snap_en;
        cur_dp = load ? bus.dp_in  : snap_dp;
        cnt_nx = cnt;
        idx_nx = idx;
        if (bus.en) begin
            cnt_nx = tick ? '0 : cnt + 1'b1;
            if (tick)
                idx_nx = (idx == ILAST) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt     <= '0;
            idx     <= '0;
            snap_x  <= '0;
            snap_en <= '0;
            snap_dp <= '0;
        end else begin
            cnt <= cnt_nx;
            idx <= idx_nx;
            if (load) begin
                snap_x  <= cur_x;
                snap_en <= cur_en;
                snap_dp <= cur_dp;
            end
        end
    end

    // Phase FSM: state register
    always_ff @(posedge clk) begin
        if (clr) st <= ST_RST;
        else     st <= st_nx;
    end

    // Phase FSM: next state, always consistent with the next count
    always_comb begin
        st_nx = (cnt_nx < CBLK) ? BLANK : DRIVE;
    end

    // Phase FSM: outputs (registered below, so they lag cnt/idx by one)
    always_comb begin
        an_nx    = '1;
        dp_nx    = 1'b1;
        digit_nx = digit_q;
        fd_nx    = 1'b0;
        if (bus.en) begin
            digit_nx = cur_x[idx];
            fd_nx    = tick && (idx == ILAST);
            if (st == DRIVE) begin
                // Only the current slot's anode can go low.
                an_nx[idx] = ~cur_en[idx];
                dp_nx      = ~(cur_dp[idx] & cur_en[idx]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            an_q    <= '1;
            dp_q    <= 1'b1;
            digit_q <= '0;
            fd_q    <= 1'b0;
        end else begin
            an_q    <= an_nx;
            dp_q    <= dp_nx;
            digit_q <= digit_nx;
            fd_q    <= fd_nx;
        end
    end

    assign bus.an         = an_q;
    assign bus.dp         = dp_q;
    assign bus.digit      = digit_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with NDIG=6, DIV_MAX=3, BLANK_CYC=1
// (4-clock slots, 24-clock frames).
module tb_seg_scan_ctrl;
    localparam int NDIG = 6;
    localparam int DM   = 3;
    localparam int BC   = 1;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.NDIG(NDIG)) bus ();

    seg_scan_ctrl #(
        .NDIG(NDIG), .DIV_W(16), .DIV_MAX(DM), .BLANK_CYC(BC)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int                m_cnt = 0, m_idx = 0;
    logic [23:0]       m_x = '0;
    logic [5:0]        m_en = '0, m_dp = '0;
    logic [3:0]        m_dig = '0;

    // Expected word: {an[5:0], dp, digit[3:0], frame_done}
    logic [11:0] sb[$];
    int          gaps[$];
    int          cyc = 0, last_fd = 0;
    bit          coll_dig = 0, coll4 = 0;
    logic [3:0]  digs[$];
    int          ndp0 = 0, nlow = 0;

    function automatic logic [11:0] model_step();
        logic [11:0] e;
        logic [23:0] lx;
        logic [5:0]  le, ld, a;
        logic [3:0]  nib;
        logic        d, fd;
        if (clr) begin
            m_cnt = 0; m_idx = 0; m_x = '0; m_en = '0; m_dp = '0; m_dig = '0;
            e = {6'h3f, 1'b1, 4'h0, 1'b0};
        end else if (!bus.en) begin
            e = {6'h3f, 1'b1, m_dig, 1'b0};
        end else begin
            if (m_cnt == 0 && m_idx == 0) begin
                m_x = bus.x; m_en = bus.dig_en; m_dp = bus.dp_in;
            end
            lx = m_x; le = m_en; ld = m_dp;
            nib = lx[m_idx*4 +: 4];
            a = 6'h3f;
            d = 1'b1;
            if (m_cnt >= BC) begin
                a[m_idx] = ~le[m_idx];
                d = ~(ld[m_idx] & le[m_idx]);
            end
            fd = (m_cnt == DM) && (m_idx == NDIG-1);
            e = {a, d, nib, fd};
            m_dig = nib;
            if (m_cnt == DM) begin
                m_cnt = 0;
                m_idx = (m_idx == NDIG-1) ? 0 : m_idx + 1;
            end else begin
                m_cnt++;
            end
        end
        return e;
    endfunction

    task automatic step();
        logic [11:0] got;
        sb.push_back(model_step());
        @(posedge clk);
        @(negedge clk);
        cyc++;
        got = {bus.an, bus.dp, bus.digit, bus.frame_done};
        chk("out", 32'(got), 32'(sb.pop_front()));
        chk("one_an", 32'($countones(~bus.an) <= 1), 32'd1);
        if (bus.frame_done) begin
            gaps.push_back(cyc - last_fd);
            last_fd = cyc;
        end
        if (coll_dig && bus.an != 6'h3f) digs.push_back(bus.digit);
        if (coll4) begin
            if (!bus.dp) ndp0++;
            if (bus.an != 6'h3f) nlow++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [3:0] exp_dig [6];
        int         exp_gap [6];
        exp_dig = '{4'h9, 4'h5, 4'h9, 4'h5, 4'h3, 4'h2};
        exp_gap = '{24, 24, 24, 24, 34, 24};

        clr = 1'b1;
        bus.en = 1'b0; bus.x = '0; bus.dig_en = '0; bus.dp_in = '0;
        @(negedge clk);
        run(2);
        chk("rst", 32'({bus.an, bus.dp, bus.digit, bus.frame_done}),
            32'({6'h3f, 1'b1, 4'h0, 1'b0}));

        // Frame 1: plain scan of 23:59:59
        clr = 1'b0;
        bus.en = 1'b1; bus.x = 24'h235959; bus.dig_en = 6'h3f; bus.dp_in = '0;
        last_fd = cyc;
        coll_dig = 1;
        run(24);
        coll_dig = 0;
        chk("f1_ndig", 32'(digs.size()), 32'd18);
        for (int s = 0; s < 6; s++)
            if (digs.size() == 18) chk("f1_dig", 32'(digs[3*s]), 32'(exp_dig[s]));

        // Frame 2: x changes during slot 2, must not tear
        run(10);
        bus.x = 24'h000000;
        run(14);

        // Frame 3 shows zeros; new flags set after its snapshot
        run(1);
        bus.x = 24'h235959; bus.dig_en = 6'b011111; bus.dp_in = 6'b000100;
        run(23);

        // Frame 4: digit 5 blanked, dp on digit 2
        coll4 = 1;
        run(24);
        coll4 = 0;
        chk("f4_dp0", 32'(ndp0), 32'd3);
        chk("f4_anlow", 32'(nlow), 32'd15);

        // Frame 5: en dropped for 10 clocks at slot 3, cnt 2
        run(14);
        bus.en = 1'b0;
        run(10);
        bus.en = 1'b1;
        run(10);

        // Frame 6: clr in slot 4, then restart with fresh snapshot
        run(18);
        clr = 1'b1;
        run(1);
        clr = 1'b0;
        bus.x = 24'h124007;
        last_fd = cyc;
        run(26);

        chk("ngaps", 32'(gaps.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < gaps.size()) chk("fd_gap", 32'(gaps[i]), 32'(exp_gap[i]));

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nerr);
        $finish;
    end
endmodule
